// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: parametrised multi-read-port register file with a pending-write
// scoreboard and a sequenced bulk-clear engine.
//
// Optional feature macro: RF_WRITE_BYPASS_EN
//   defined   -> a writeback in IDLE/DONE is forwarded to matching read ports in
//                the same cycle (data and pending bit).
//   undefined -> reads show registered contents only.
//
// Ports:
//   clk         clock, all state on posedge
//   rst         asynchronous active-low reset
//   rd_addr     NUM_RD packed read indices (port k at [k*ADDR_W +: ADDR_W])
//   rd_data     NUM_RD packed read data    (port k at [k*DATA_W +: DATA_W])
//   rd_pending  per-port outstanding-producer flag
//   wb_en/wb_addr/wb_data        writeback
//   issue_en/issue_addr          destination issue (sets pending)
//   clr_req/clr_busy/clr_done    bulk-clear handshake

// One read port: range check, optional bypass mux, then the register/pending lookup.
module regfile_mp_sb_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 15
) (
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
  input  logic [DEPTH-1:0]              pend,
  input  logic                          byp_en,
  input  logic [ADDR_W-1:0]             byp_addr,
  input  logic [DATA_W-1:0]             byp_data,
  input  logic                          byp_pend,
  output logic [DATA_W-1:0]             data,
  output logic                          pending
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic in_range;
  logic hit;

  always_comb begin
    in_range = ({1'b0, addr} < DEPTH_L);
    // byp_en already implies byp_addr is in range
    hit      = byp_en && (addr == byp_addr);
    data     = '0;
    pending  = 1'b0;
    if (hit) begin
      data    = byp_data;
      pending = byp_pend;
    end else if (in_range) begin
      data    = regs[addr];
      pending = pend[addr];
    end
  end
endmodule

module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 15,
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pending,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done
);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            cnt;
  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pend;

  logic start;
  logic accept;
  logic wb_in_range;
  logic wb_ok;
  logic iss_ok;
  logic byp_en;
  logic byp_pend;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE:    if (clr_req) begin
                 state_nxt = CLEAR;
                 start     = 1'b1;
               end
      CLEAR:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The cycle that launches a clear swallows any writeback/issue alongside it.
  assign accept      = (state != CLEAR) && !start;
  assign wb_in_range = ({1'b0, wb_addr} < DEPTH_L);
  assign wb_ok       = accept && wb_en && wb_in_range;
  assign iss_ok      = accept && issue_en && ({1'b0, issue_addr} < DEPTH_L);

  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      regs  <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        cnt  <= '0;
        pend <= '0;
      end else if (state == CLEAR) begin
        regs[cnt] <= '0;
        cnt       <= cnt + 1'b1;
      end else begin
        if (wb_ok) begin
          regs[wb_addr] <= wb_data;
          pend[wb_addr] <= 1'b0;
        end
        // issue after writeback: a new producer wins over a retiring one
        if (iss_ok) pend[issue_addr] <= 1'b1;
      end
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  assign byp_en = (state != CLEAR) && wb_en && wb_in_range;
`else
  assign byp_en = 1'b0;
`endif
  assign byp_pend = issue_en && (issue_addr == wb_addr);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_mp_sb_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
    ) u_rd (
      .addr     (rd_addr[k*ADDR_W +: ADDR_W]),
      .regs     (regs),
      .pend     (pend),
      .byp_en   (byp_en),
      .byp_addr (wb_addr),
      .byp_data (wb_data),
      .byp_pend (byp_pend),
      .data     (rd_data[k*DATA_W +: DATA_W]),
      .pending  (rd_pending[k])
    );
  end
endmodule
